painterengine_gpu_reader: RTL and testbench

- DMA read engine that answers the GPU block-reader request interface: address/length/enable in, a word stream plus done/error out.
- Fetches the requested 32-bit words from memory over an AXI4 read-only master (AR/R channels).
- Splits each request into INCR bursts that never cross a 4 KB boundary.
- Sits between the display controller (stream consumer, which writes every valid word into its FIFO) and the memory interconnect.

---
 rtl/painterengine_gpu_pkg.sv | 19 +
 rtl/painterengine_gpu_reader_if.sv | 26 ++
 rtl/painterengine_gpu_burst_calc.sv | 33 +++
 rtl/painterengine_gpu_reader.sv | 177 +++++++++++++++++
 tb/tb_painterengine_gpu_reader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared states and AXI constants for the GPU block reader
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam int         PAGE_BYTES = 4096;

endpackage

// File: rtl/painterengine_gpu_reader_if.sv
// rtl/painterengine_gpu_reader_if.sv - AXI4 read address/data channels of the block reader
interface painterengine_gpu_reader_if;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/painterengine_gpu_burst_calc.sv
// rtl/painterengine_gpu_burst_calc.sv - beats of the next burst, capped by length, max burst and 4 KB page
module painterengine_gpu_burst_calc
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_MAX_BURST = 16
) (
  input  logic [31:0] remaining,
  input  logic [31:0] addr,
  output logic [8:0]  beats,
  output logic [7:0]  arlen
);

  logic [12:0] page_left;
  logic [10:0] page_beats;
  logic [8:0]  cap;

  always_comb begin
    // 13 bits so a page-aligned address yields the full 4096 bytes
    page_left  = 13'(PAGE_BYTES) - {1'b0, addr[11:0]};
    page_beats = page_left[12:2];
    cap        = 9'(PARAM_MAX_BURST);
    if (page_beats < {2'b00, cap}) begin
      cap = page_beats[8:0];
    end
    if (remaining < {23'd0, cap}) begin
      beats = remaining[8:0];
    end else begin
      beats = cap;
    end
    arlen = 8'(beats - 9'd1);
  end

endmodule

// File: rtl/painterengine_gpu_reader.sv
// rtl/painterengine_gpu_reader.sv - DMA read engine: request in, AXI4 INCR bursts out, word stream back
module painterengine_gpu_reader
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_MAX_BURST = 16
) (
  input  logic                          i_wire_clock,
  input  logic                          i_wire_reset,
  input  logic [31:0]                   i_wire_address,
  input  logic [31:0]                   i_wire_length,
  input  logic                          i_wire_resetn,
  output logic                          o_wire_done,
  output logic                          o_wire_error,
  output logic [31:0]                   o_wire_data,
  output logic                          o_wire_data_valid,
  input  logic                          i_wire_data_next,
  painterengine_gpu_reader_if.master    axi,
  output logic [31:0]                   o_wire_state
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] remaining_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        arvalid_q;
  logic [8:0]  beats_q;
  logic [8:0]  beat_cnt;
  logic        err_flag;
  logic        abort_q;
  logic        done_q;
  logic        error_q;
  logic [8:0]  calc_beats;
  logic [7:0]  calc_arlen;
  logic        rready;
  logic        beat;
  logic        last_exp;
  logic        beat_err;

  painterengine_gpu_burst_calc #(
    .PARAM_MAX_BURST(PARAM_MAX_BURST)
  ) u_burst_calc (
    .remaining(remaining_q),
    .addr     (addr_q),
    .beats    (calc_beats),
    .arlen    (calc_arlen)
  );

  always_comb begin
    rready   = (state == DATA) ? i_wire_data_next : (state == DRAIN);
    beat     = axi.rvalid && rready;
    last_exp = (beat_cnt == beats_q - 9'd1);
    // a faulty beat is dropped on the spot, later beats via the sticky flag
    beat_err = (axi.rresp != RESP_OKAY) || (axi.rlast != last_exp);
    o_wire_data_valid = (state == DATA) && axi.rvalid && i_wire_data_next
                        && !err_flag && !beat_err;
  end

  assign o_wire_data  = axi.rdata;
  assign o_wire_done  = done_q;
  assign o_wire_error = error_q;
  assign o_wire_state = {29'd0, state};
  assign axi.araddr   = araddr_q;
  assign axi.arlen    = arlen_q;
  assign axi.arsize   = SIZE_4B;
  assign axi.arburst  = BURST_INCR;
  assign axi.arvalid  = arvalid_q;
  assign axi.rready   = rready;

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      beats_q     <= '0;
      beat_cnt    <= '0;
      err_flag    <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_wire_resetn) begin
            if (i_wire_length == 32'd0) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else if (i_wire_address[1:0] != 2'b00) begin
              error_q <= 1'b1;
              state   <= ERROR;
            end else begin
              addr_q      <= i_wire_address;
              remaining_q <= i_wire_length;
              err_flag    <= 1'b0;
              abort_q     <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          if (!i_wire_resetn) begin
            state <= IDLE;
          end else begin
            araddr_q  <= addr_q;
            arlen_q   <= calc_arlen;
            beats_q   <= calc_beats;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // arvalid cannot be withdrawn, so an abort is remembered until the handshake
          if (!i_wire_resetn) begin
            abort_q <= 1'b1;
          end
          if (axi.arready) begin
            arvalid_q   <= 1'b0;
            addr_q      <= addr_q + {21'd0, beats_q, 2'b00};
            remaining_q <= remaining_q - {23'd0, beats_q};
            beat_cnt    <= '0;
            state       <= (abort_q || !i_wire_resetn) ? DRAIN : DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (beat_err) begin
              err_flag <= 1'b1;
            end
            if (last_exp) begin
              if (!i_wire_resetn) begin
                state <= IDLE;
              end else if (err_flag || beat_err) begin
                error_q <= 1'b1;
                state   <= ERROR;
              end else if (remaining_q == 32'd0) begin
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                state <= CALC;
              end
            end else if (!i_wire_resetn) begin
              state <= DRAIN;
            end
          end else if (!i_wire_resetn) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (last_exp) begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          if (!i_wire_resetn) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        ERROR: begin
          if (!i_wire_resetn) begin
            error_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_reader.sv
// tb/tb_painterengine_gpu_reader.sv - randomized bench with AXI slave and burst/stream reference model
module tb_painterengine_gpu_reader;

  logic        clk;
  logic        rst;
  logic [31:0] req_addr;
  logic [31:0] req_len;
  logic        req_en;
  logic        done;
  logic        error;
  logic [31:0] data;
  logic        data_valid;
  logic        data_next;
  logic [31:0] state_o;

  painterengine_gpu_reader_if axi_bus ();

  painterengine_gpu_reader #(.PARAM_MAX_BURST(16)) dut (
    .i_wire_clock     (clk),
    .i_wire_reset     (rst),
    .i_wire_address   (req_addr),
    .i_wire_length    (req_len),
    .i_wire_resetn    (req_en),
    .o_wire_done      (done),
    .o_wire_error     (error),
    .o_wire_data      (data),
    .o_wire_data_valid(data_valid),
    .i_wire_data_next (data_next),
    .axi              (axi_bus),
    .o_wire_state     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [31:0] exp_data[$];

  // slave and stimulus state
  bit          s_busy = 0;
  logic [31:0] s_addr = 0;
  int          s_len = 0;
  int          s_idx = 0;
  int          s_beat_total = 0;
  int          err_abs = 0;
  int          arp = 100;
  int          rvp = 100;
  int          dn_mode = 2;
  bit          hold_ar = 0;
  bit          abort_mode = 0;
  bit          hs_ar = 0;
  bit          hs_r = 0;
  logic [31:0] ar_a = 0;
  logic [7:0]  ar_l = 0;
  bit          saw_arvalid = 0;
  int          valid_count = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // reference: split into page-safe bursts of at most 16 beats; an error beat ends the job
  task automatic plan_job(logic [31:0] a, logic [31:0] len, int err_beat);
    logic [31:0] cur;
    int rem, b, room, issued;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_data.delete();
    if (len == 0 || a[1:0] != 2'b00) return;
    cur = a;
    rem = int'(len);
    issued = 0;
    while (rem > 0) begin
      if (err_beat != 0 && issued >= err_beat) break;
      room = (4096 - int'(cur % 4096)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_ar_addr.push_back(cur);
      exp_ar_len.push_back(8'(b - 1));
      cur = cur + 32'(4 * b);
      rem -= b;
      issued += b;
    end
    for (int k = 0; k < int'(len); k++) begin
      if (err_beat == 0 || k < err_beat - 1) exp_data.push_back(mem_word(a + 32'(4 * k)));
    end
  endtask

  // one clock: drive inputs on the falling edge, sample and score 1 ns later
  task automatic step();
    @(negedge clk);
    if (rst) begin
      s_busy = 0;
      hs_ar = 0;
      hs_r = 0;
      axi_bus.arready = 1'b0;
      axi_bus.rvalid = 1'b0;
    end else begin
      if (hs_r) begin
        s_idx++;
        s_beat_total++;
        if (s_idx == s_len) s_busy = 0;
      end
      if (hs_ar) begin
        s_busy = 1;
        s_addr = ar_a;
        s_len = int'(ar_l) + 1;
        s_idx = 0;
      end
      axi_bus.arready = !s_busy && !hold_ar && (int'($urandom_range(99)) < arp);
      if (s_busy) begin
        if (!(axi_bus.rvalid && !hs_r)) axi_bus.rvalid = (int'($urandom_range(99)) < rvp);
        axi_bus.rdata = mem_word(s_addr + 32'(4 * s_idx));
        axi_bus.rlast = (s_idx == s_len - 1);
        axi_bus.rresp = (s_beat_total + 1 == err_abs) ? 2'b10 : 2'b00;
      end else begin
        axi_bus.rvalid = 1'b0;
        axi_bus.rdata = $urandom;
        axi_bus.rlast = 1'b0;
        axi_bus.rresp = 2'b00;
      end
      case (dn_mode)
        0: data_next = ($urandom_range(99) < 60);
        1: data_next = !data_next;
        default: data_next = 1'b1;
      endcase
    end
    #1;
    if (!rst) begin
      if (axi_bus.arvalid) saw_arvalid = 1;
      hs_ar = axi_bus.arvalid && axi_bus.arready;
      hs_r = axi_bus.rvalid && axi_bus.rready;
      ar_a = axi_bus.araddr;
      ar_l = axi_bus.arlen;
      if (hs_ar) begin
        if (exp_ar_addr.size() == 0) begin
          check("ar_unexpected", 1, 0);
        end else begin
          check("araddr", axi_bus.araddr, exp_ar_addr.pop_front());
          check("arlen", 32'(axi_bus.arlen), 32'(exp_ar_len.pop_front()));
          check("arsize", 32'(axi_bus.arsize), 32'd2);
          check("arburst", 32'(axi_bus.arburst), 32'd1);
        end
      end
      if (s_busy) begin
        if (abort_mode) check("rready_drain", 32'(axi_bus.rready), 32'd1);
        else check("rready_tracks_next", 32'(axi_bus.rready), 32'(data_next));
      end
      if (data_valid) begin
        valid_count++;
        if (exp_data.size() == 0) check("data_unexpected", 1, 0);
        else check("data", data, exp_data.pop_front());
      end
    end
  endtask

  task automatic run_job(string tag, logic [31:0] a, logic [31:0] len, int err_beat,
                         int ap, int rp, int dm);
    int exp_fwd, base, cyc;
    bit want_err;
    plan_job(a, len, err_beat);
    exp_fwd = exp_data.size();
    base = valid_count;
    arp = ap;
    rvp = rp;
    dn_mode = dm;
    err_abs = (err_beat != 0) ? s_beat_total + err_beat : 0;
    want_err = (len != 0) && (a[1:0] != 2'b00 || err_beat != 0);
    saw_arvalid = 0;
    req_addr = a;
    req_len = len;
    req_en = 1'b1;
    cyc = 0;
    while (!(done || error) && cyc < 3000) begin
      step();
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 3000), 1);
    check({tag, "_done"}, 32'(done), 32'(!want_err));
    check({tag, "_error"}, 32'(error), 32'(want_err));
    check({tag, "_words"}, 32'(valid_count - base), 32'(exp_fwd));
    check({tag, "_ar_left"}, 32'(exp_ar_addr.size()), 0);
    if (len == 0 || a[1:0] != 2'b00) begin
      check({tag, "_latency"}, 32'(cyc <= 2), 1);
      check({tag, "_no_arvalid"}, 32'(saw_arvalid), 0);
    end
    req_en = 1'b0;
    step();
    step();
    check({tag, "_cleared"}, {state_o[29:0], done, error}, 0);
    err_abs = 0;
  endtask

  initial begin
    int c, base;
    logic [31:0] ra;
    rst = 1'b1;
    req_addr = 0;
    req_len = 0;
    req_en = 1'b0;
    data_next = 1'b1;
    axi_bus.arready = 1'b0;
    axi_bus.rvalid = 1'b0;
    axi_bus.rdata = 0;
    axi_bus.rresp = 0;
    axi_bus.rlast = 0;
    step();
    step();
    #2;
    check("reset_state", state_o, 0);
    check("reset_flags", {30'd0, done, error}, 0);
    check("reset_ar", {axi_bus.arvalid, axi_bus.arlen, 23'd0}, 0);
    check("reset_araddr", axi_bus.araddr, 0);
    rst = 1'b0;
    step();

    plan_job(32'h1000, 64, 0);
    check("model_t1_bursts", 32'(exp_ar_addr.size()), 4);
    check("model_t1_ar3", exp_ar_addr[3], 32'h10C0);
    check("model_t1_len", 32'(exp_ar_len[0]), 15);
    plan_job(32'h0FF8, 8, 0);
    check("model_t2_ar0", {exp_ar_addr[0][23:0], exp_ar_len[0]}, 32'h000FF801);
    check("model_t2_ar1", {exp_ar_addr[1][23:0], exp_ar_len[1]}, 32'h00100005);

    run_job("aligned64", 32'h1000, 64, 0, 100, 100, 2);
    run_job("cross4k", 32'h0FF8, 8, 0, 100, 100, 2);
    run_job("len0", 32'h4000, 0, 0, 100, 100, 2);
    run_job("misaligned", 32'h1002, 4, 0, 100, 100, 2);
    run_job("slverr", 32'h2000, 16, 3, 100, 100, 2);
    run_job("toggle", 32'h5000, 32, 0, 100, 100, 1);
    run_job("wrap", 32'hFFFFFFF0, 8, 0, 100, 100, 2);
    for (int j = 0; j < 8; j++) begin
      ra = ($urandom & 32'hFFFFF000) + 32'h1000 - 32'(4 * $urandom_range(1, 40));
      run_job("random", ra, 32'($urandom_range(1, 50)), 0,
              int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0);
    end

    // abort while the address is stalled
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_data.delete();
    exp_ar_addr.push_back(32'h2000);
    exp_ar_len.push_back(8'd15);
    base = valid_count;
    hold_ar = 1;
    rvp = 100;
    dn_mode = 0;
    req_addr = 32'h2000;
    req_len = 40;
    req_en = 1'b1;
    c = 0;
    while (!axi_bus.arvalid && c < 20) begin step(); c++; end
    check("abort_arvalid_seen", 32'(axi_bus.arvalid), 1);
    req_en = 1'b0;
    abort_mode = 1;
    step();
    step();
    step();
    check("abort_arvalid_held", 32'(axi_bus.arvalid), 1);
    hold_ar = 0;
    arp = 100;
    c = 0;
    while (!s_busy && c < 100) begin step(); c++; end
    while (s_busy && c < 300) begin step(); c++; end
    check("abort_drain_timeout", 32'(c < 300), 1);
    step();
    step();
    check("abort_idle", state_o, 0);
    check("abort_no_words", 32'(valid_count - base), 0);
    check("abort_ar_left", 32'(exp_ar_addr.size()), 0);
    abort_mode = 0;

    // asynchronous reset in the middle of a data phase
    plan_job(32'h3000, 64, 0);
    base = valid_count;
    arp = 100;
    rvp = 100;
    dn_mode = 2;
    req_addr = 32'h3000;
    req_len = 64;
    req_en = 1'b1;
    c = 0;
    while (valid_count - base < 5 && c < 500) begin step(); c++; end
    check("rst_mid_started", 32'(valid_count - base >= 5), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_state", state_o, 0);
    check("rst_async_out", {26'd0, axi_bus.arvalid, axi_bus.rready, data_valid, done, error, 1'b0}, 0);
    check("rst_async_ar", {axi_bus.araddr[23:0], axi_bus.arlen}, 0);
    req_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_data.delete();
    step();
    step();
    check("rst_release_idle", state_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
